// File: rtl/boot_load_ctrl.sv
// Boot loader: streams a length-prefixed image from a byte receiver into instruction memory.
// Build macro BOOT_CSUM_EN adds a trailing modulo-256 checksum byte (error code 3 on mismatch).
module boot_load_ctrl #(
  parameter int          MAX_LEN = 32,
  parameter logic [12:0] TIMEOUT = 13'd5207
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       Load,
  input  logic       Byte_Valid,
  input  logic [7:0] Byte_Data,
  input  logic       FE,
  output logic       Rx_Clear,
  output logic       Wr_En,
  output logic [4:0] Wr_Addr,
  output logic [7:0] Wr_Data,
  output logic       CPU_Hold,
  output logic       Done,
  output logic [1:0] Err_Code,
  output logic [5:0] Byte_Count
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_LEN   = 3'd2;
  localparam logic [2:0] S_DATA  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERR   = 3'd6;
`ifdef BOOT_CSUM_EN
  localparam logic [2:0] S_CSUM  = 3'd4;
  localparam logic [1:0] ERR_CSUM = 2'd3;
`endif
  localparam logic [1:0] ERR_LEN  = 2'd1;
  localparam logic [1:0] ERR_LINK = 2'd2;
  localparam logic [7:0] MAX_LEN_B = 8'(MAX_LEN);

  logic [2:0]  r_state;
  logic        r_load_q;
  logic [5:0]  r_len;
  logic [12:0] r_timer;
  logic        w_load_rise;
  logic        w_link_fault;
  logic        w_len_ok;
  logic        w_timed_out;
  logic [5:0]  w_count_inc;
  logic [12:0] w_timer_inc;

  assign w_load_rise  = Load & ~r_load_q;
  // A framing error or the operator releasing Load aborts any active load phase
  assign w_link_fault = FE | ~Load;
  assign w_len_ok     = (Byte_Data != 8'd0) && (Byte_Data <= MAX_LEN_B);
  assign w_count_inc  = Byte_Count + 6'd1;
  assign w_timer_inc  = r_timer + 13'd1;
  assign w_timed_out  = (w_timer_inc == TIMEOUT);

`ifdef BOOT_CSUM_EN
  logic [7:0] r_sum;
  logic       w_accept;

  assign w_accept = (r_state == S_DATA) & Byte_Valid & ~w_link_fault & ~w_load_rise;

  // Running modulo-256 sum of accepted payload bytes
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_sum <= 8'd0;
    end else if (w_load_rise) begin
      r_sum <= 8'd0;
    end else if (w_accept) begin
      r_sum <= r_sum + Byte_Data;
    end else begin
      r_sum <= r_sum;
    end
  end
`endif

  // Load sequencer and all registered outputs
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_load_q   <= 1'b0;
      r_len      <= 6'd0;
      r_timer    <= 13'd0;
      Rx_Clear   <= 1'b0;
      Wr_En      <= 1'b0;
      Wr_Addr    <= 5'd0;
      Wr_Data    <= 8'd0;
      CPU_Hold   <= 1'b0;
      Done       <= 1'b0;
      Err_Code   <= 2'd0;
      Byte_Count <= 6'd0;
    end else begin
      r_load_q <= Load;
      Rx_Clear <= 1'b0;
      Wr_En    <= 1'b0;
      if (w_load_rise) begin
        r_state    <= S_CLEAR;
        Rx_Clear   <= 1'b1;
        CPU_Hold   <= 1'b1;
        Done       <= 1'b0;
        Err_Code   <= 2'd0;
        Byte_Count <= 6'd0;
        r_timer    <= 13'd0;
      end else begin
        case (r_state)
          S_CLEAR: r_state <= S_LEN;
          S_LEN: begin
            if (w_link_fault) begin
              r_state  <= S_ERR;
              Err_Code <= ERR_LINK;
            end else if (Byte_Valid) begin
              if (w_len_ok) begin
                r_len   <= Byte_Data[5:0];
                r_timer <= 13'd0;
                r_state <= S_DATA;
              end else begin
                r_state  <= S_ERR;
                Err_Code <= ERR_LEN;
              end
            end else begin
              r_state <= S_LEN;
            end
          end
          S_DATA: begin
            if (w_link_fault) begin
              r_state  <= S_ERR;
              Err_Code <= ERR_LINK;
            end else if (Byte_Valid) begin
              Wr_En      <= 1'b1;
              Wr_Addr    <= Byte_Count[4:0];
              Wr_Data    <= Byte_Data;
              Byte_Count <= w_count_inc;
              r_timer    <= 13'd0;
              if (w_count_inc == r_len) begin
`ifdef BOOT_CSUM_EN
                r_state <= S_CSUM;
`else
                r_state  <= S_DONE;
                Done     <= 1'b1;
                CPU_Hold <= 1'b0;
`endif
              end else begin
                r_state <= S_DATA;
              end
            end else if (w_timed_out) begin
              r_state  <= S_ERR;
              Err_Code <= ERR_LINK;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
`ifdef BOOT_CSUM_EN
          S_CSUM: begin
            if (w_link_fault) begin
              r_state  <= S_ERR;
              Err_Code <= ERR_LINK;
            end else if (Byte_Valid) begin
              if (Byte_Data == r_sum) begin
                r_state  <= S_DONE;
                Done     <= 1'b1;
                CPU_Hold <= 1'b0;
              end else begin
                r_state  <= S_ERR;
                Err_Code <= ERR_CSUM;
              end
            end else if (w_timed_out) begin
              r_state  <= S_ERR;
              Err_Code <= ERR_LINK;
            end else begin
              r_timer <= w_timer_inc;
            end
          end
`endif
          S_IDLE, S_DONE, S_ERR: r_state <= r_state;
          // Unreachable encodings fail safe: CPU stays held until a fresh load
          default: begin
            r_state  <= S_ERR;
            CPU_Hold <= 1'b1;
            Done     <= 1'b0;
            Err_Code <= ERR_LINK;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/boot_load_ctrl.md
BOOT_LOAD_CTRL -- requirements
Module: boot_load_ctrl

Interface
REQ-001 SHALL provide parameter MAX_LEN, default 32, meaning the largest legal payload length in bytes (1..32).
REQ-002 SHALL provide parameter TIMEOUT, default 13'd5207, meaning the Clk cycles allowed between consecutive bytes after the length byte.
REQ-003 SHALL have port Clk  input  1  system clock; all state changes on posedge Clk.
REQ-004 SHALL have port Reset  input  1  reset; one clock; reset is asynchronous and active-high.
REQ-005 SHALL have port Load  input  1  operator load switch (level, already synchronous to Clk).
REQ-006 SHALL have port Byte_Valid  input  1  one-cycle pulse, receiver has a complete byte.
REQ-007 SHALL have port Byte_Data  input  8  received byte, valid when Byte_Valid=1.
REQ-008 SHALL have port FE  input  1  receiver framing error, sampled every cycle.
REQ-009 SHALL have port Rx_Clear  output  1  one-cycle pulse restarting the receiver.
REQ-010 SHALL have port Wr_En, Wr_Addr[4:0], Wr_Data[7:0]  outputs  instruction-memory write strobe, byte address, byte.
REQ-011 SHALL have port CPU_Hold  output  1  holds the CPU while loading or after a failure.
REQ-012 SHALL have ports Done  output  1, Err_Code  output  2 (0 none, 1 length, 2 framing/timeout/abort, 3 checksum).
REQ-013 SHALL have port Byte_Count  output  6  payload bytes written in the current load.

Function
REQ-014 SHALL register Load internally and detect its rising edge (Load=1, Load_q=0).
REQ-015 SHALL implement states IDLE, CLEAR, LEN, DATA, CSUM, DONE, ERR.
REQ-016 SHALL, on a Load rising edge in any state, enter CLEAR next cycle; this takes priority over every other transition.
REQ-017 CLEAR: SHALL last exactly one cycle with Rx_Clear=1, zero Byte_Count, running sum, timeout counter and Err_Code, then enter LEN.
REQ-018 LEN: on Byte_Valid with Byte_Data in 1..MAX_LEN, SHALL store length and enter DATA; 0 or >MAX_LEN -> ERR, code 1; no timeout in LEN.
REQ-019 DATA: on Byte_Valid SHALL assert Wr_En for one cycle on the next cycle with Wr_Addr=Byte_Count, Wr_Data=Byte_Data (latency 1), increment Byte_Count, add Byte_Data to an 8-bit sum modulo 256.
REQ-020 DATA: when the accepted byte makes Byte_Count equal the stored length, SHALL enter CSUM.
REQ-021 CSUM: on Byte_Valid, Byte_Data equal to sum -> DONE; otherwise -> ERR, code 3.
REQ-022 SHALL reload the timeout counter on each Byte_Valid and on entry to DATA; counter reaching TIMEOUT in DATA or CSUM -> ERR, code 2.
REQ-023 FE=1 or Load=0 in LEN, DATA or CSUM SHALL -> ERR, code 2.
REQ-024 Byte_Valid coincident with FE SHALL be discarded: no write, no count, ERR code 2.
REQ-025 CPU_Hold SHALL be 0 in IDLE and DONE, 1 in all other states.
REQ-026 Done SHALL be 1 only in DONE; DONE and ERR SHALL persist until the next Load rising edge or Reset.
REQ-027 Byte_Count SHALL never exceed MAX_LEN; Wr_Addr SHALL not wrap within one load.

Reset
REQ-028 On Reset: state IDLE, Rx_Clear=0, Wr_En=0, Wr_Addr=0, Wr_Data=0, CPU_Hold=0, Done=0, Err_Code=0, Byte_Count=0, sum=0, Load_q=0.
REQ-029 Reset mid-load SHALL abandon the load immediately with no further writes.

Configuration
REQ-030 With macro BOOT_CSUM_EN defined, the CSUM state and code 3 SHALL exist as in REQ-021.
REQ-031 Without BOOT_CSUM_EN, DATA SHALL go directly to DONE after the last byte, no sum logic SHALL be built, and Err_Code SHALL never be 3.

Verification
REQ-032 Load rise, bytes 0x03,0x10,0x20,0x30,0x60 -> Rx_Clear pulse; writes addr0..2 = 0x10,0x20,0x30; Done=1, CPU_Hold=0, Byte_Count=3.
REQ-033 Same load with checksum 0x61 -> ERR, Err_Code=3, CPU_Hold=1, Done=0; with BOOT_CSUM_EN undefined -> Done after 0x30.
REQ-034 Length byte 0x00, then 0x21 on a fresh load -> ERR code 1 both times, no Wr_En.
REQ-035 Length 0x02, one data byte, then silence TIMEOUT cycles -> ERR code 2, exactly one write.
REQ-036 FE pulse with Byte_Valid in DATA -> no write, ERR code 2; new Load rise -> CLEAR, Err_Code=0, full load succeeds.
